// File: rtl/bp_mcore_looper_mc.sv
// bp_mcore_looper_mc: multi-context hardware loop-iteration allocator.
//
// Cores claim index chunks with NEXT reads, report finished iterations with
// DONE writes, and get a level interrupt per context when its loop completes.
// Commands queue in a small FIFO. The head is answered combinationally.
// Register side effects apply only on the response handshake.
//
// Optional build macro: BP_MCORE_LOOPER_PERF_EN adds a per-context counter
// of granted non-empty NEXT allocations (register 6).
//
// Message layout: {data[dword], msg_type[3:0], size[2:0], addr[paddr]}.
// msg_type encoding: rd=0, wr=1, uc_rd=2, uc_wr=3.
//
// Per-context state machine:
//   state    | meaning
//   IDLE     | not armed; NEXT returns an empty range
//   ACTIVE   | handing out chunks of [START, END)
//   DRAINING | all chunks granted, waiting for DONE to reach END-START
//   DONE     | loop complete; irq raised if irq_en was set
module bp_mcore_looper_mc #(
  parameter int bp_params_p   = 0,
  parameter int num_ctx_p     = 4,
  parameter int els_p         = 2,
  parameter int idx_width_p   = 32,
  localparam int paddr_width_lp       = (bp_params_p == 0) ? 40 : 56,
  localparam int dword_width_lp       = 64,
  localparam int mem_hdr_width_lp     = 4 + 3 + paddr_width_lp,
  localparam int cce_mem_msg_width_lp = mem_hdr_width_lp + dword_width_lp
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i,
  output logic [num_ctx_p-1:0]            irq_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    DRAINING = 2'd2,
    DONE     = 2'd3
  } ctx_state_e;

  localparam logic [3:0] MSG_WR    = 4'd1;
  localparam logic [3:0] MSG_UC_WR = 4'd3;

  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_START = 3'd1;
  localparam logic [2:0] REG_END   = 3'd2;
  localparam logic [2:0] REG_CHUNK = 3'd3;
  localparam logic [2:0] REG_NEXT  = 3'd4;
  localparam logic [2:0] REG_DONE  = 3'd5;
  localparam logic [2:0] REG_PERF  = 3'd6;

  localparam int ctx_w_lp = (num_ctx_p > 1) ? $clog2(num_ctx_p) : 1;
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic [mem_hdr_width_lp-1:0] hdr_mem   [els_p];
  logic [idx_width_p-1:0]      wdata_mem [els_p];
  logic [ptr_w_lp-1:0]         wptr_r, rptr_r;
  logic [cnt_w_lp-1:0]         count_r;
  logic                        ready_r;
  logic                        full, enq, deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign full            = (count_r == cnt_w_lp'(els_p));
  assign mem_resp_v_o    = (count_r != '0);
  assign deq             = mem_resp_v_o & mem_resp_yumi_i;
  // A full FIFO can still take a command in the cycle its head is consumed.
  assign mem_cmd_ready_o = ready_r & (~full | deq);
  assign enq             = mem_cmd_v_i & mem_cmd_ready_o;

  // FIFO pointers, occupancy and the post-reset ready flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ready_r <= 1'b0;
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      ready_r <= 1'b1;
      if (enq) wptr_r <= ptr_inc(wptr_r);
      if (deq) rptr_r <= ptr_inc(rptr_r);
      if (enq && !deq)      count_r <= count_r + cnt_w_lp'(1);
      else if (!enq && deq) count_r <= count_r - cnt_w_lp'(1);
    end
  end

  // FIFO storage; only the header and the index-wide part of the data are kept.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      hdr_mem[wptr_r]   <= mem_cmd_i[mem_hdr_width_lp-1:0];
      wdata_mem[wptr_r] <= mem_cmd_i[mem_hdr_width_lp +: idx_width_p];
    end
  end

  // ---------------------------------------------------------------------
  // Head decode
  // ---------------------------------------------------------------------
  logic [mem_hdr_width_lp-1:0] head_hdr;
  logic [idx_width_p-1:0]      head_data;
  logic [3:0]                  head_type;
  logic [2:0]                  head_reg;
  logic [ctx_w_lp-1:0]         head_ctx;
  logic                        head_wr;

  assign head_hdr  = hdr_mem[rptr_r];
  assign head_data = wdata_mem[rptr_r];
  assign head_type = head_hdr[mem_hdr_width_lp-1 -: 4];
  assign head_reg  = head_hdr[5:3];
  assign head_ctx  = (num_ctx_p > 1) ? head_hdr[6 +: ctx_w_lp] : '0;
  assign head_wr   = (head_type == MSG_WR) || (head_type == MSG_UC_WR);

  // ---------------------------------------------------------------------
  // Per-context state
  // ---------------------------------------------------------------------
  ctx_state_e             state_r     [num_ctx_p];
  ctx_state_e             state_n     [num_ctx_p];
  logic [idx_width_p-1:0] start_r     [num_ctx_p];
  logic [idx_width_p-1:0] start_n     [num_ctx_p];
  logic [idx_width_p-1:0] end_r       [num_ctx_p];
  logic [idx_width_p-1:0] end_n       [num_ctx_p];
  logic [idx_width_p-1:0] chunk_r     [num_ctx_p];
  logic [idx_width_p-1:0] chunk_n     [num_ctx_p];
  logic [idx_width_p-1:0] next_r      [num_ctx_p];
  logic [idx_width_p-1:0] next_n      [num_ctx_p];
  logic [idx_width_p-1:0] completed_r [num_ctx_p];
  logic [idx_width_p-1:0] completed_n [num_ctx_p];
  logic [num_ctx_p-1:0]   irq_r, irq_n;
  logic [num_ctx_p-1:0]   irq_en_r, irq_en_n;
`ifdef BP_MCORE_LOOPER_PERF_EN
  logic [31:0]            perf_r      [num_ctx_p];
  logic [31:0]            perf_n      [num_ctx_p];
`endif

  // Values of the addressed context, all taken from pre-commit state.
  ctx_state_e             sel_state;
  logic [idx_width_p-1:0] sel_start, sel_end, sel_chunk, sel_next, sel_completed;
  logic                   sel_busy;

  assign sel_state     = state_r[head_ctx];
  assign sel_start     = start_r[head_ctx];
  assign sel_end       = end_r[head_ctx];
  assign sel_chunk     = chunk_r[head_ctx];
  assign sel_next      = next_r[head_ctx];
  assign sel_completed = completed_r[head_ctx];
  assign sel_busy      = (sel_state == ACTIVE) || (sel_state == DRAINING);

  // Allocation uses one extra bit so next+chunk cannot wrap past END.
  logic [idx_width_p-1:0] eff_chunk, alloc_hi, total, done_new;
  logic [idx_width_p:0]   alloc_sum, done_sum;

  assign eff_chunk = (sel_chunk == '0) ? idx_width_p'(1) : sel_chunk;
  assign alloc_sum = {1'b0, sel_next} + {1'b0, eff_chunk};
  assign alloc_hi  = (alloc_sum >= {1'b0, sel_end}) ? sel_end : alloc_sum[idx_width_p-1:0];

  // Completion count saturates at the loop trip count.
  assign total    = (sel_end > sel_start) ? (sel_end - sel_start) : '0;
  assign done_sum = {1'b0, sel_completed} + {1'b0, head_data};
  assign done_new = (done_sum >= {1'b0, total}) ? total : done_sum[idx_width_p-1:0];

  // Read data for the FIFO head; writes answer with zero data.
  logic [dword_width_lp-1:0] rdata;

  always_comb begin
    rdata = '0;
    if (!head_wr) begin
      unique case (head_reg)
        REG_CTRL:  rdata[5:0] = {sel_state, 1'b0, irq_r[head_ctx], irq_en_r[head_ctx],
                                 (sel_state != IDLE)};
        REG_START: rdata[idx_width_p-1:0] = sel_start;
        REG_END:   rdata[idx_width_p-1:0] = sel_end;
        REG_CHUNK: rdata[idx_width_p-1:0] = sel_chunk;
        REG_NEXT:  rdata[2*idx_width_p-1:0] = (sel_state == ACTIVE) ? {alloc_hi, sel_next}
                                                                    : {sel_end, sel_end};
        REG_DONE:  rdata[idx_width_p-1:0] = sel_completed;
`ifdef BP_MCORE_LOOPER_PERF_EN
        REG_PERF:  rdata[31:0] = perf_r[head_ctx];
`endif
        default:   rdata = '0;
      endcase
    end
  end

  assign mem_resp_o = {rdata, head_hdr};
  assign irq_o      = irq_r;

  // Next-state and register updates, applied only on the response handshake.
  always_comb begin
    state_n     = state_r;
    start_n     = start_r;
    end_n       = end_r;
    chunk_n     = chunk_r;
    next_n      = next_r;
    completed_n = completed_r;
    irq_n       = irq_r;
    irq_en_n    = irq_en_r;
`ifdef BP_MCORE_LOOPER_PERF_EN
    perf_n      = perf_r;
`endif
    if (deq) begin
      if (head_wr) begin
        unique case (head_reg)
          REG_CTRL: begin
            irq_en_n[head_ctx] = head_data[1];
            if (head_data[2]) irq_n[head_ctx] = 1'b0;
            if (!head_data[0]) begin
              state_n[head_ctx] = IDLE;
              irq_n[head_ctx]   = 1'b0;
            end else if (!sel_busy) begin
              next_n[head_ctx]      = sel_start;
              completed_n[head_ctx] = '0;
              irq_n[head_ctx]       = 1'b0;
              state_n[head_ctx]     = (sel_start >= sel_end) ? DONE : ACTIVE;
`ifdef BP_MCORE_LOOPER_PERF_EN
              perf_n[head_ctx]      = '0;
`endif
            end
          end
          REG_START: if (!sel_busy) start_n[head_ctx] = head_data;
          REG_END:   if (!sel_busy) end_n[head_ctx]   = head_data;
          REG_CHUNK: if (!sel_busy) chunk_n[head_ctx] = head_data;
          REG_DONE: begin
            if (sel_state != IDLE) begin
              completed_n[head_ctx] = done_new;
              if (sel_state == DRAINING && done_new >= total) begin
                state_n[head_ctx] = DONE;
                irq_n[head_ctx]   = irq_en_r[head_ctx];
              end
            end
          end
`ifdef BP_MCORE_LOOPER_PERF_EN
          REG_PERF:  perf_n[head_ctx] = '0;
`endif
          default: ;
        endcase
      end else if (head_reg == REG_NEXT && sel_state == ACTIVE) begin
        next_n[head_ctx] = alloc_hi;
`ifdef BP_MCORE_LOOPER_PERF_EN
        if (alloc_hi != sel_next) perf_n[head_ctx] = perf_r[head_ctx] + 32'd1;
`endif
        if (alloc_hi == sel_end) begin
          // Completions may already cover the loop when the last chunk goes out.
          if (sel_completed >= total) begin
            state_n[head_ctx] = DONE;
            irq_n[head_ctx]   = irq_en_r[head_ctx];
          end else begin
            state_n[head_ctx] = DRAINING;
          end
        end
      end
    end
  end

  // Context register file and state machines.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_ctx_p; i++) begin
        state_r[i]     <= IDLE;
        start_r[i]     <= '0;
        end_r[i]       <= '0;
        chunk_r[i]     <= '0;
        next_r[i]      <= '0;
        completed_r[i] <= '0;
`ifdef BP_MCORE_LOOPER_PERF_EN
        perf_r[i]      <= '0;
`endif
      end
      irq_r    <= '0;
      irq_en_r <= '0;
    end else begin
      state_r     <= state_n;
      start_r     <= start_n;
      end_r       <= end_n;
      chunk_r     <= chunk_n;
      next_r      <= next_n;
      completed_r <= completed_n;
`ifdef BP_MCORE_LOOPER_PERF_EN
      perf_r      <= perf_n;
`endif
      irq_r       <= irq_n;
      irq_en_r    <= irq_en_n;
    end
  end

endmodule

// File: tb/tb_bp_mcore_looper_mc.sv
// Self-checking bench for bp_mcore_looper_mc: table of register accesses
// grouped in phases, a response scoreboard, and hand-written sequences for
// response back-pressure and a full command FIFO.
module tb_bp_mcore_looper_mc;

  localparam int HDR_W = 47;
  localparam int MSG_W = HDR_W + 64;

`ifdef BP_MCORE_LOOPER_PERF_EN
  localparam logic [63:0] PERF_EXP = 64'd3;
`else
  localparam logic [63:0] PERF_EXP = 64'd0;
`endif

  logic             clk_i = 1'b0;
  logic             reset_n_i = 1'b0;
  logic [MSG_W-1:0] mem_cmd_i = '0;
  logic             mem_cmd_v_i = 1'b0;
  logic             mem_cmd_ready_o;
  logic [MSG_W-1:0] mem_resp_o;
  logic             mem_resp_v_o;
  logic             mem_resp_yumi_i;
  logic [3:0]       irq_o;
  logic             yumi_en = 1'b1;

  bp_mcore_looper_mc dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .mem_cmd_i       (mem_cmd_i),
    .mem_cmd_v_i     (mem_cmd_v_i),
    .mem_cmd_ready_o (mem_cmd_ready_o),
    .mem_resp_o      (mem_resp_o),
    .mem_resp_v_o    (mem_resp_v_o),
    .mem_resp_yumi_i (mem_resp_yumi_i),
    .irq_o           (irq_o)
  );

  always #5 clk_i = ~clk_i;

  assign mem_resp_yumi_i = yumi_en & mem_resp_v_o;

  typedef struct {
    int          phase;
    logic        wr;
    int          ctx;
    int          rg;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [HDR_W-1:0] hdr;
    logic [63:0]      data;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic add(input int phase, input logic wr, input int ctx, input int rg,
                     input logic [63:0] data, input logic [63:0] exp);
    vec_t v;
    v.phase = phase; v.wr = wr; v.ctx = ctx; v.rg = rg; v.data = data; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [HDR_W-1:0] make_hdr(input logic wr, input int ctx, input int rg);
    logic [39:0] addr;
    logic [3:0]  ty;
    addr      = 40'h80_0030_0000;
    addr[5:3] = rg[2:0];
    addr[7:6] = ctx[1:0];
    if (wr) ty = rg[0] ? 4'd1 : 4'd3;
    else    ty = rg[0] ? 4'd0 : 4'd2;
    return {ty, 3'd3, addr};
  endfunction

  // Scoreboard: every consumed response is matched against the oldest expectation.
  always @(negedge clk_i) begin
    if (reset_n_i && mem_resp_v_o && mem_resp_yumi_i) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL resp_unexpected: got %h expected no response", mem_resp_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (mem_resp_o !== {e.data, e.hdr}) begin
          miscompares++;
          $display("FAIL resp: got %h expected %h", mem_resp_o, {e.data, e.hdr});
        end
      end
    end
  end

  task automatic send(input logic wr, input int ctx, input int rg,
                      input logic [63:0] data, input logic [63:0] exp);
    exp_t e;
    int   n;
    e.hdr  = make_hdr(wr, ctx, rg);
    e.data = exp;
    mem_cmd_i   = {data, e.hdr};
    mem_cmd_v_i = 1'b1;
    n = 0;
    while (!mem_cmd_ready_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL cmd_accept_timeout: got ready 0 expected 1");
      mem_cmd_v_i = 1'b0;
    end else begin
      @(posedge clk_i); #1;
      mem_cmd_v_i = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    yumi_en = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || mem_resp_v_o) && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 100) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_phase(input int phase);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].phase == phase)
        send(tbl[i].wr, tbl[i].ctx, tbl[i].rg, tbl[i].data, tbl[i].exp);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // phase 1: ctx0 loop 0..10 chunk 4, hand out all chunks, partial DONE
    add(1, 0, 0, 0, 64'd0, 64'h0);
    add(1, 1, 0, 1, 64'd0, 64'h0);
    add(1, 1, 0, 2, 64'd10, 64'h0);
    add(1, 1, 0, 3, 64'd4, 64'h0);
    add(1, 1, 0, 0, 64'h3, 64'h0);
    add(1, 0, 0, 0, 64'd0, 64'h13);
    add(1, 0, 0, 4, 64'd0, 64'h00000004_00000000);
    add(1, 0, 0, 4, 64'd0, 64'h00000008_00000004);
    add(1, 0, 0, 4, 64'd0, 64'h0000000A_00000008);
    add(1, 0, 0, 0, 64'd0, 64'h23);
    add(1, 0, 0, 4, 64'd0, 64'h0000000A_0000000A);
    add(1, 1, 0, 1, 64'd100, 64'h0);
    add(1, 0, 0, 1, 64'd0, 64'h0);
    add(1, 0, 0, 2, 64'd0, 64'hA);
    add(1, 1, 0, 5, 64'd6, 64'h0);
    // phase 2: completion
    add(2, 1, 0, 5, 64'd4, 64'h0);
    add(2, 0, 0, 0, 64'd0, 64'h37);
    add(2, 0, 0, 5, 64'd0, 64'hA);
    add(2, 0, 0, 6, 64'd0, PERF_EXP);
    add(2, 1, 0, 7, 64'hFF, 64'h0);
    add(2, 0, 0, 7, 64'd0, 64'h0);
    // phase 3: W1C + disarm, DONE write in IDLE is ignored
    add(3, 1, 0, 0, 64'h6, 64'h0);
    add(3, 0, 0, 0, 64'd0, 64'h02);
    add(3, 1, 0, 5, 64'd3, 64'h0);
    add(3, 0, 0, 5, 64'd0, 64'hA);
    // phase 4: re-arm ctx0 without irq_en
    add(4, 1, 0, 0, 64'h1, 64'h0);
    // phase 5: after held response, allocation continues from 4
    add(5, 0, 0, 4, 64'd0, 64'h00000008_00000004);
    // phase 6: ctx1 top-of-range without wrap, then CHUNK=0
    add(6, 1, 1, 1, 64'hFFFFFFF0, 64'h0);
    add(6, 1, 1, 2, 64'hFFFFFFFF, 64'h0);
    add(6, 1, 1, 3, 64'h20, 64'h0);
    add(6, 1, 1, 0, 64'h1, 64'h0);
    add(6, 0, 1, 4, 64'd0, 64'hFFFFFFFF_FFFFFFF0);
    add(6, 0, 1, 0, 64'd0, 64'h21);
    add(6, 1, 1, 0, 64'h0, 64'h0);
    add(6, 1, 1, 1, 64'd0, 64'h0);
    add(6, 1, 1, 2, 64'd3, 64'h0);
    add(6, 1, 1, 3, 64'd0, 64'h0);
    add(6, 1, 1, 0, 64'h1, 64'h0);
    add(6, 0, 1, 4, 64'd0, 64'h00000001_00000000);
    add(6, 0, 1, 4, 64'd0, 64'h00000002_00000001);
    add(6, 0, 1, 0, 64'd0, 64'h11);
    // ctx2 empty loop
    add(6, 1, 2, 1, 64'd5, 64'h0);
    add(6, 1, 2, 2, 64'd5, 64'h0);
    add(6, 1, 2, 0, 64'h1, 64'h0);
    add(6, 0, 2, 0, 64'd0, 64'h31);
    add(6, 0, 2, 4, 64'd0, 64'h00000005_00000005);
    // phase 7: interleaved ctx0 / ctx3
    add(7, 1, 3, 1, 64'd20, 64'h0);
    add(7, 1, 3, 2, 64'd30, 64'h0);
    add(7, 1, 3, 3, 64'd5, 64'h0);
    add(7, 1, 3, 0, 64'h1, 64'h0);
    add(7, 0, 3, 4, 64'd0, 64'h00000019_00000014);
    add(7, 0, 0, 4, 64'd0, 64'h0000000A_00000008);
    add(7, 0, 3, 4, 64'd0, 64'h0000001E_00000019);
    add(7, 0, 0, 0, 64'd0, 64'h21);
    add(7, 0, 3, 0, 64'd0, 64'h21);
    add(7, 1, 3, 5, 64'd10, 64'h0);
    add(7, 0, 3, 0, 64'd0, 64'h31);
    add(7, 0, 0, 5, 64'd0, 64'h0);
    add(7, 0, 3, 5, 64'd0, 64'hA);

    // reset state
    #12;
    check("reset_ready", {63'd0, mem_cmd_ready_o}, 64'd0);
    check("reset_resp_v", {63'd0, mem_resp_v_o}, 64'd0);
    check("reset_irq", {60'd0, irq_o}, 64'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("ready_after_reset", {63'd0, mem_cmd_ready_o}, 64'd1);

    run_phase(1);
    check("irq_after_done6", {60'd0, irq_o}, 64'd0);
    run_phase(2);
    check("irq_after_done4", {60'd0, irq_o}, 64'd1);
    run_phase(3);
    check("irq_after_w1c", {60'd0, irq_o}, 64'd0);
    run_phase(4);

    // response held for 5 cycles
    yumi_en = 1'b0;
    send(1'b0, 0, 4, 64'd0, 64'h00000004_00000000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      check("hold_resp_v", {63'd0, mem_resp_v_o}, 64'd1);
      check("hold_resp_data", mem_resp_o[HDR_W +: 64], 64'h00000004_00000000);
    end
    drain();
    run_phase(5);

    // fill the FIFO, then consume and enqueue in the same cycle
    yumi_en = 1'b0;
    send(1'b0, 0, 1, 64'd0, 64'h0);
    send(1'b0, 0, 2, 64'd0, 64'hA);
    check("ready_when_full", {63'd0, mem_cmd_ready_o}, 64'd0);
    yumi_en = 1'b1;
    #1;
    check("ready_full_with_yumi", {63'd0, mem_cmd_ready_o}, 64'd1);
    send(1'b0, 0, 3, 64'd0, 64'h4);
    drain();

    run_phase(6);
    check("irq_ctx1_ctx2", {60'd0, irq_o}, 64'd0);
    run_phase(7);
    check("irq_final", {60'd0, irq_o}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
